// File: rtl/flappy_pkg.sv
// Shared constants for the flappy renderer: colours, game-state encoding and the visible window.
package flappy_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      PLAY = 2'b01,
      DEAD = 2'b10
   } gameState_t;

   localparam logic [11:0] BLACK  = 12'h000;
   localparam logic [11:0] WHITE  = 12'hFFF;
   localparam logic [11:0] RED    = 12'hF00;
   localparam logic [11:0] GREEN  = 12'h0F0;
   localparam logic [11:0] YELLOW = 12'hFF0;

   localparam logic [10:0] H_VIS_LO = 11'd144;
   localparam logic [10:0] H_VIS_HI = 11'd783;
   localparam logic [10:0] V_VIS_LO = 11'd35;
   localparam logic [10:0] V_VIS_HI = 11'd514;

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD incrementer that saturates at 9999; clr has priority over inc.
module bcd_counter4 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        inc,
   output logic [15:0] count
);

   logic [15:0] countNext;
   logic        carry;

   always_comb begin
      countNext = count;
      carry     = 1'b1;
      for (int d = 0; d < 4; d++) begin
         if (carry) begin
            if (count[4*d +: 4] == 4'd9) begin
               countNext[4*d +: 4] = 4'd0;
            end else begin
               countNext[4*d +: 4] = count[4*d +: 4] + 4'd1;
               carry               = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          count <= 16'h0000;
      else if (clr)                        count <= 16'h0000;
      else if (inc && count != 16'h9999)   count <= countNext;
   end

endmodule

// File: rtl/flappy_frame_renderer.sv
// Bird/pipe pixel colouriser with game FSM, collision detection and BCD pass scoring.
// Optional DEATH_FLASH_EN: background flashes RED/BLACK every 16 frames while DEAD.
module flappy_frame_renderer
   import flappy_pkg::*;
#(
   parameter int NUM_PIPES   = 2,
   parameter int PIPE_HALF_W = 50,
   parameter int GAP_H       = 100,
   parameter int BIRD_HALF   = 10
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   bright,
   input  logic                   button,
   input  logic [9:0]             hCount,
   input  logic [9:0]             vCount,
   input  logic [9:0]             BirdX,
   input  logic [9:0]             BirdY,
   input  logic [10*NUM_PIPES-1:0] PipeX,
   input  logic [10*NUM_PIPES-1:0] PipeY,
   output logic [11:0]            rgb,
   output logic [15:0]            score,
   output logic [1:0]             game_state,
   output logic                   collided
);

   localparam int          PW  = $clog2(NUM_PIPES + 1);
   localparam logic [10:0] PHW = 11'(PIPE_HALF_W);
   localparam logic [10:0] GAP = 11'(GAP_H);
   localparam logic [10:0] BH  = 11'(BIRD_HALF);

   gameState_t           state, stateNext;
   logic                 rstSync1, rstN;
   logic [10:0]          h, v, bx, by;
   logic                 frameTick, btnPrev, btnRise, inVis, birdHit, pixColl, edgeHit;
   logic                 collFlag, collNow, startGame, collidedNext;
   logic [NUM_PIPES-1:0] pipeHit, passVec, passArm;
   logic [PW-1:0]        pending, passCnt;
   logic [11:0]          rgbNext, bgColour, rgb_p1;

   // Clamped lower bound keeps shapes near the left/top edge partially visible.
   function automatic logic inSpan(input logic [10:0] p, input logic [10:0] c,
                                   input logic [10:0] half);
      logic [10:0] lo;
      lo = (c > half) ? c - half : 11'd0;
      return (p >= lo) && (p <= c + half);
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) {rstN, rstSync1} <= 2'b00;
      else        {rstN, rstSync1} <= {rstSync1, 1'b1};
   end

   assign h         = {1'b0, hCount};
   assign v         = {1'b0, vCount};
   assign bx        = {1'b0, BirdX};
   assign by        = {1'b0, BirdY};
   assign frameTick = (hCount == 10'd0) && (vCount == 10'd0);
   assign btnRise   = button && !btnPrev;
   assign inVis     = (h >= H_VIS_LO) && (h <= H_VIS_HI) && (v >= V_VIS_LO) && (v <= V_VIS_HI);
   assign birdHit   = inSpan(h, bx, BH) && inSpan(v, by, BH);
   assign pixColl   = inVis && birdHit && (|pipeHit);
   assign edgeHit   = (by + BH > V_VIS_HI) || (by < V_VIS_LO + BH);
   assign collNow   = collFlag || pixColl || edgeHit;

   for (genvar i = 0; i < NUM_PIPES; i++) begin : gPipe
      logic [10:0] px, py;
      logic [9:0]  prevX;
      assign px          = {1'b0, PipeX[10*i +: 10]};
      assign py          = {1'b0, PipeY[10*i +: 10]};
      assign pipeHit[i]  = inSpan(h, px, PHW) && ((v <= py) || (v >= py + GAP));
      assign passVec[i]  = passArm[i] && ({1'b0, prevX} > bx) && (px <= bx);
      always_ff @(posedge clk) begin
         if (frameTick) prevX <= px[9:0];
      end
   end

   always_comb begin
      passCnt = '0;
      for (int i = 0; i < NUM_PIPES; i++) passCnt = passCnt + PW'(passVec[i]);
   end

   always_comb begin
      stateNext    = state;
      collidedNext = 1'b0;
      startGame    = 1'b0;
      case (state)
         IDLE: if (btnRise) begin
            stateNext = PLAY;
            startGame = 1'b1;
         end
         PLAY: if (frameTick && collNow) begin
            stateNext    = DEAD;
            collidedNext = 1'b1;
         end
         DEAD: if (btnRise) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // Passes found at a frame tick queue in pending and drain one point per clock.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state    <= IDLE;
         collided <= 1'b0;
         btnPrev  <= 1'b0;
         collFlag <= 1'b0;
         passArm  <= '0;
         pending  <= '0;
      end else begin
         state    <= stateNext;
         collided <= collidedNext;
         btnPrev  <= button;
         collFlag <= (state == PLAY) && !frameTick && (collFlag || pixColl);
         if (startGame)      passArm <= '0;
         else if (frameTick) passArm <= '1;
         if (startGame) pending <= '0;
         else pending <= pending - PW'(pending != '0)
                         + (((state == PLAY) && frameTick) ? passCnt : '0);
      end
   end

   bcd_counter4 uBcd (
      .clk   (clk),
      .rst_n (rstN),
      .clr   (startGame),
      .inc   (pending != '0),
      .count (score)
   );

`ifdef DEATH_FLASH_EN
   logic [4:0] flashCnt;
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN)               flashCnt <= 5'd0;
      else if (state != DEAD)  flashCnt <= 5'd0;
      else if (frameTick)      flashCnt <= flashCnt + 5'd1;
   end
   assign bgColour = ((state == DEAD) && flashCnt[4]) ? BLACK : RED;
`else
   assign bgColour = RED;
`endif

   always_comb begin
      if (!bright)       rgbNext = BLACK;
      else if (|pipeHit) rgbNext = GREEN;
      else if (birdHit)  rgbNext = (state == DEAD) ? YELLOW : WHITE;
      else               rgbNext = bgColour;
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) rgb_p1 <= BLACK;
      else       rgb_p1 <= rgbNext;
   end

   assign rgb        = rgb_p1;
   assign game_state = state;

endmodule

// File: tb/tb_flappy_frame_renderer.sv
// Directed bench for flappy_frame_renderer: colour vector table plus FSM/scoring sequences.
module tb_flappy_frame_renderer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        bright = 1'b0;
   logic        button = 1'b0;
   logic [9:0]  hCount = 10'd5;
   logic [9:0]  vCount = 10'd5;
   logic [9:0]  BirdX = 10'd200;
   logic [9:0]  BirdY = 10'd200;
   logic [19:0] PipeX = {10'd1000, 10'd1000};
   logic [19:0] PipeY = {10'd300, 10'd300};
   logic [11:0] rgb;
   logic [15:0] score;
   logic [1:0]  game_state;
   logic        collided;
   int          errors = 0;
   int          checks = 0;

   typedef struct {
      logic        br;
      logic [9:0]  h, v, bx, by, px0, py0;
      logic [11:0] exp;
   } vec_t;
   vec_t vecs [14];

   always #5 clk = ~clk;

   flappy_frame_renderer #(.NUM_PIPES(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bright     (bright),
      .button     (button),
      .hCount     (hCount),
      .vCount     (vCount),
      .BirdX      (BirdX),
      .BirdY      (BirdY),
      .PipeX      (PipeX),
      .PipeY      (PipeY),
      .rgb        (rgb),
      .score      (score),
      .game_state (game_state),
      .collided   (collided)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      hCount = 10'd0;
      vCount = 10'd0;
      step();
      hCount = 10'd5;
      vCount = 10'd5;
   endtask

   task automatic setPipes(input logic [9:0] x0, input logic [9:0] y0,
                           input logic [9:0] x1, input logic [9:0] y1);
      PipeX = {x1, x0};
      PipeY = {y1, y0};
   endtask

   // One round scores 2 points (both pipes) or 1 point (pipe 0 only) with BirdX=200.
   task automatic passRound(input bit both);
      setPipes(10'd201, 10'd300, both ? 10'd201 : 10'd1000, 10'd300);
      tick();
      setPipes(10'd199, 10'd300, both ? 10'd199 : 10'd1000, 10'd300);
      tick();
      repeat (3) step();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "bench watchdog expired");
   end

   initial begin
      vecs = '{
         '{1'b1, 10'd300, 10'd200, 10'd300, 10'd200, 10'd1000, 10'd150, 12'hFFF},
         '{1'b0, 10'd300, 10'd200, 10'd300, 10'd200, 10'd1000, 10'd150, 12'h000},
         '{1'b1, 10'd400, 10'd200, 10'd300, 10'd200, 10'd1000, 10'd150, 12'hF00},
         '{1'b1, 10'd400, 10'd100, 10'd300, 10'd200, 10'd400,  10'd150, 12'h0F0},
         '{1'b1, 10'd400, 10'd150, 10'd300, 10'd200, 10'd400,  10'd150, 12'h0F0},
         '{1'b1, 10'd400, 10'd151, 10'd300, 10'd200, 10'd400,  10'd150, 12'hF00},
         '{1'b1, 10'd400, 10'd249, 10'd300, 10'd200, 10'd400,  10'd150, 12'hF00},
         '{1'b1, 10'd400, 10'd250, 10'd300, 10'd200, 10'd400,  10'd150, 12'h0F0},
         '{1'b1, 10'd450, 10'd100, 10'd300, 10'd200, 10'd400,  10'd150, 12'h0F0},
         '{1'b1, 10'd451, 10'd100, 10'd300, 10'd200, 10'd400,  10'd150, 12'hF00},
         '{1'b1, 10'd0,   10'd100, 10'd300, 10'd200, 10'd20,   10'd150, 12'h0F0},
         '{1'b1, 10'd310, 10'd210, 10'd300, 10'd200, 10'd1000, 10'd150, 12'hFFF},
         '{1'b1, 10'd311, 10'd210, 10'd300, 10'd200, 10'd1000, 10'd150, 12'hF00},
         '{1'b1, 10'd300, 10'd200, 10'd300, 10'd200, 10'd300,  10'd250, 12'h0F0}
      };

      step();
      chk("reset_rgb", 32'(rgb), 32'h000);
      chk("reset_score", 32'(score), 32'h0000);
      chk("reset_state", 32'(game_state), 32'h0);
      chk("reset_collided", 32'(collided), 32'h0);
      rst_n = 1'b1;
      repeat (3) step();

      for (int i = 0; i < 14; i++) begin
         bright = vecs[i].br;
         hCount = vecs[i].h;
         vCount = vecs[i].v;
         BirdX  = vecs[i].bx;
         BirdY  = vecs[i].by;
         setPipes(vecs[i].px0, vecs[i].py0, 10'd1000, 10'd300);
         step();
         chk($sformatf("colour_vec%0d", i), 32'(rgb), 32'(vecs[i].exp));
      end

      hCount = 10'd5;
      vCount = 10'd5;
      BirdX  = 10'd200;
      BirdY  = 10'd200;
      setPipes(10'd1000, 10'd300, 10'd1000, 10'd300);
      button = 1'b1;
      step();
      chk("start_state", 32'(game_state), 32'h1);
      chk("start_score", 32'(score), 32'h0000);
      repeat (4) step();
      chk("start_held_state", 32'(game_state), 32'h1);
      button = 1'b0;
      step();

      setPipes(10'd201, 10'd300, 10'd201, 10'd300);
      tick();
      setPipes(10'd199, 10'd300, 10'd199, 10'd300);
      tick();
      repeat (2) step();
      chk("pass_two_score", 32'(score), 32'h0002);
      tick();
      repeat (3) step();
      chk("no_repass_score", 32'(score), 32'h0002);

      repeat (20) passRound(1'b1);
      chk("score_42", 32'(score), 32'h0042);
      chk("pre_reset_rgb", 32'(rgb), 32'hF00);
      rst_n = 1'b0;
      #1;
      chk("async_rst_score", 32'(score), 32'h0000);
      chk("async_rst_state", 32'(game_state), 32'h0);
      chk("async_rst_rgb", 32'(rgb), 32'h000);
      chk("async_rst_collided", 32'(collided), 32'h0);
      step();
      rst_n = 1'b1;
      repeat (3) step();
      button = 1'b1;
      step();
      button = 1'b0;
      chk("restart_state", 32'(game_state), 32'h1);
      step();

      repeat (499) passRound(1'b1);
      passRound(1'b0);
      chk("bcd_0999", 32'(score), 32'h0999);
      passRound(1'b0);
      chk("bcd_1000", 32'(score), 32'h1000);
      repeat (4499) passRound(1'b1);
      passRound(1'b0);
      chk("bcd_9999", 32'(score), 32'h9999);
      passRound(1'b1);
      chk("bcd_saturate", 32'(score), 32'h9999);

      BirdX = 10'd300;
      BirdY = 10'd140;
      setPipes(10'd300, 10'd150, 10'd1000, 10'd300);
      hCount = 10'd300;
      vCount = 10'd140;
      step();
      hCount = 10'd5;
      vCount = 10'd5;
      chk("hit_before_tick_state", 32'(game_state), 32'h1);
      step();
      tick();
      chk("collide_state", 32'(game_state), 32'h2);
      chk("collide_pulse", 32'(collided), 32'h1);
      step();
      chk("collide_pulse_end", 32'(collided), 32'h0);
      chk("dead_score_hold", 32'(score), 32'h9999);

      BirdX  = 10'd600;
      hCount = 10'd600;
      vCount = 10'd140;
      step();
      chk("dead_bird_yellow", 32'(rgb), 32'hFF0);
      hCount = 10'd700;
      vCount = 10'd300;
      step();
      chk("dead_background", 32'(rgb), 32'hF00);
      hCount = 10'd5;
      vCount = 10'd5;

      button = 1'b1;
      step();
      button = 1'b0;
      chk("dead_to_idle", 32'(game_state), 32'h0);
      chk("idle_score_hold", 32'(score), 32'h9999);
      step();
      BirdX = 10'd200;
      BirdY = 10'd500;
      setPipes(10'd1000, 10'd300, 10'd1000, 10'd300);
      button = 1'b1;
      step();
      button = 1'b0;
      chk("replay_state", 32'(game_state), 32'h1);
      chk("replay_score_clear", 32'(score), 32'h0000);
      step();
      tick();
      chk("bottom_edge_ok", 32'(game_state), 32'h1);
      BirdY = 10'd505;
      tick();
      chk("bottom_edge_dead", 32'(game_state), 32'h2);
      chk("bottom_edge_pulse", 32'(collided), 32'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
